// File: rtl/spi_flash_pkg.sv
// Shared types and opcodes for the SPI flash responder.
// The opcode decoder lives here so any future responder variant decodes commands the same way.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        STAT,
        IGNORE
    } flash_state_e;

    localparam logic [7:0] OPC_READ = 8'h03;
    localparam logic [7:0] OPC_RDID = 8'h9F;
    localparam logic [7:0] OPC_RDSR = 8'h05;

    function automatic flash_state_e decode_opcode(input logic [7:0] opc);
        case (opc)
            OPC_READ: return ADDR;
            OPC_RDID: return ID;
            OPC_RDSR: return STAT;
            default:  return IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the SPI pins into the clk domain and detects SCK edges and the CSN falling edge.
// The sck and csn chains each carry one extra flop so that edges are seen on synchronized values.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_i,
    input  logic csn_i,
    input  logic sdi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic csn_o,
    output logic csn_fall_o,
    output logic sdi_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sck_prev_q;
    logic                   csn_prev_q;

    // csn resets to "selected" so a frame that was open across reset never
    // produces a falling edge; the master must deselect and reselect first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            csn_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
            csn_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the previous
            // stage's old value; blocking ones would collapse the chain to one flop.
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            csn_prev_q <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise_o = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign csn_o      = csn_sync_q[SYNC_STAGES-1];
    assign csn_fall_o = ~csn_sync_q[SYNC_STAGES-1] & csn_prev_q;
    assign sdi_o      = sdi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving READ, RDID and RDSR from a 1-cycle synchronous read port.
// All logic runs in the clk domain on oversampled SPI pins.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'h010219,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck_i,
    input  logic              spi_csn_i,
    input  logic              spi_sdi_i,
    output logic              spi_sdo_o,
    output logic              spi_sdo_oe_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic [7:0]        status_i,
    output logic              busy_o
);

    logic sck_rise, sck_fall, csn_s, csn_fall, sdi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck_i      (spi_sck_i),
        .csn_i      (spi_csn_i),
        .sdi_i      (spi_sdi_i),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .csn_o      (csn_s),
        .csn_fall_o (csn_fall),
        .sdi_o      (sdi_s)
    );

    flash_state_e      state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       addr_q, addr_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              sdo_q, sdo_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    // The last shifted-in bit completes the opcode/address in the same clk it arrives.
    logic [7:0]  opcode;
    logic [23:0] full_addr;
    logic [7:0]  id_byte;

    assign opcode    = {rx_q, sdi_s};
    assign full_addr = {addr_q, sdi_s};

    always_comb begin
        case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default up front so no path leaves one
        // unassigned, which is what would otherwise infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        id_idx_d   = id_idx_q;
        sdo_d      = sdo_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_valid_d = 1'b0;

        if (csn_s) begin
            // Deselect beats any same-cycle SCK edge and drops an in-flight read.
            state_d   = IDLE;
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
            id_idx_d  = '0;
            sdo_d     = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            rd_valid_d = mem_req_q;
            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_d      = opcode[6:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            state_d   = decode_opcode(opcode);
                            tx_d      = (opcode == OPC_RDSR) ? status_i : JEDEC_ID[23:16];
                            id_idx_d  = 2'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_d    = full_addr[22:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = '0;
                            state_d    = DATA;
                            mem_req_d  = 1'b1;
                            mem_addr_d = full_addr[ADDR_W-1:0];
                        end
                    end
                end
                DATA, ID, STAT: begin
                    if (state_q == DATA && rd_valid_q) begin
                        tx_d = mem_rdata_i;
                    end
                    if (sck_fall) begin
                        sdo_d     = tx_q[7];
                        oe_d      = 1'b1;
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            // Byte boundary: fetch or pick the next byte ahead of the next fall.
                            bit_cnt_d = '0;
                            if (state_q == DATA) begin
                                mem_req_d  = 1'b1;
                                mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end else if (state_q == ID) begin
                                tx_d     = id_byte;
                                id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                            end else begin
                                tx_d = status_i;
                            end
                        end
                    end
                end
                IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            id_idx_q   <= '0;
            sdo_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            id_idx_q   <= id_idx_d;
            sdo_q      <= sdo_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            rd_valid_q <= rd_valid_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign spi_sdo_o    = sdo_q;
    assign spi_sdo_oe_o = oe_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed vector table, hand-written corner sequences,
// and random frames checked against a byte-level model of the flash commands.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        csn = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo;
    logic        sdo_oe;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  status = 8'h00;
    logic        busy;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_W      (24),
        .JEDEC_ID    (24'h010219),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sck_i    (sck),
        .spi_csn_i    (csn),
        .spi_sdi_i    (sdi),
        .spi_sdo_o    (sdo),
        .spi_sdo_oe_o (sdo_oe),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .status_i     (status),
        .busy_o       (busy)
    );

    // 1-cycle memory: mem[a] = a[7:0] ^ 0x5A; every request is logged.
    logic [23:0] req_log[$];
    int          oe_cycles = 0;

    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= mem_addr[7:0] ^ 8'h5A;
            req_log.push_back(mem_addr);
        end
        if (sdo_oe) oe_cycles++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what a flash answers, byte by byte.
    logic [7:0] jedec_bytes [3] = '{8'h01, 8'h02, 8'h19};

    function automatic logic [23:0] model_addr(input logic [23:0] a, input int k);
        return a + 24'(k);
    endfunction

    function automatic logic [47:0] model_bytes(input logic [7:0] opc, input logic [23:0] a,
                                                input int n, input logic [7:0] st);
        logic [47:0] r = '0;
        logic [23:0] ak;
        logic [7:0]  b;
        for (int k = 0; k < n; k++) begin
            case (opc)
                8'h03: begin ak = model_addr(a, k); b = ak[7:0] ^ 8'h5A; end
                8'h9F: b = jedec_bytes[k % 3];
                8'h05: b = st;
                default: b = 8'h00;
            endcase
            r[47-8*k -: 8] = b;
        end
        return r;
    endfunction

    // SPI master, mode 0: MOSI set while SCK low, MISO sampled at the rise.
    task automatic send_bits(input logic [31:0] mosi, input int n, output logic [31:0] miso);
        miso = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = mosi[i];
            #50;
            sck = 1'b1;
            miso = {miso[30:0], sdo};
            #50;
            sck = 1'b0;
        end
    endtask

    task automatic start_frame();
        csn = 1'b0;
        #100;
    endtask

    task automatic end_frame();
        #50;
        csn = 1'b1;
        #300;
    endtask

    task automatic do_frame(input logic [7:0] opc, input logic [23:0] a, input int n,
                            output logic [47:0] got);
        logic [31:0] m;
        got = '0;
        start_frame();
        send_bits({24'h0, opc}, 8, m);
        if (opc == 8'h03) send_bits({8'h0, a}, 24, m);
        for (int k = 0; k < n; k++) begin
            send_bits($urandom, 8, m);
            got[47-8*k -: 8] = m[7:0];
        end
        end_frame();
    endtask

    task automatic verify(input string name, input logic [7:0] opc, input logic [23:0] a,
                          input int n, input logic [7:0] st, input logic [47:0] exp,
                          input int exp_reqs);
        logic [47:0] got;
        int          q0;
        int          oe0;
        logic        exp_oe;
        q0 = req_log.size();
        oe0 = oe_cycles;
        status = st;
        do_frame(opc, a, n, got);
        check({name, " miso"}, got, exp);
        check({name, " req count"}, 48'(req_log.size() - q0), 48'(exp_reqs));
        for (int k = 0; k < exp_reqs; k++) begin
            if (q0 + k < req_log.size())
                check({name, " req addr"}, 48'(req_log[q0+k]), 48'(model_addr(a, k)));
        end
        exp_oe = (opc == 8'h03) || (opc == 8'h9F) || (opc == 8'h05);
        check({name, " oe seen"}, 48'(oe_cycles != oe0), 48'(exp_oe));
    endtask

    typedef struct {
        logic [7:0]  opc;
        logic [23:0] addr;
        int          n;
        logic [7:0]  st;
        logic [47:0] exp;
        int          reqs;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] m1, m2;
    logic [7:0]  b1, b2, ropc, rst8;
    int          q0, oe0, rn;
    logic [23:0] raddr;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h03, 24'h000010, 4, 8'h00, 48'h4A4B48490000, 5};
        vecs[1] = '{8'h03, 24'hFFFFFF, 2, 8'h00, 48'hA55A00000000, 3};
        vecs[2] = '{8'h9F, 24'h000000, 6, 8'h00, 48'h010219010219, 0};
        vecs[3] = '{8'hAB, 24'h000000, 2, 8'h00, 48'h000000000000, 0};
        vecs[4] = '{8'h05, 24'h000000, 3, 8'hC3, 48'hC3C3C3000000, 0};

        repeat (3) @(negedge clk);
        check("reset outputs", {42'h0, sdo, sdo_oe, mem_req, busy, 2'b00} | 48'(mem_addr),
              48'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++)
            verify($sformatf("vec%0d", i), vecs[i].opc, vecs[i].addr, vecs[i].n, vecs[i].st,
                   vecs[i].exp, vecs[i].reqs);

        // RDSR polling: status changes during the first data byte, seen only from the next byte.
        status = 8'h01;
        start_frame();
        send_bits(32'h05, 8, m1);
        send_bits($urandom, 3, m1);
        status = 8'h00;
        send_bits($urandom, 5, m2);
        b1 = {m1[2:0], m2[4:0]};
        send_bits($urandom, 8, m2);
        b2 = m2[7:0];
        end_frame();
        check("rdsr byte1", 48'(b1), 48'h01);
        check("rdsr byte2", 48'(b2), 48'h00);

        // Abort after 13 address bits, then a clean READ.
        q0 = req_log.size();
        start_frame();
        send_bits(32'h03, 8, m1);
        send_bits($urandom, 13, m1);
        end_frame();
        check("abort no req", 48'(req_log.size() - q0), 48'h0);
        verify("after abort", 8'h03, 24'h000020, 1, 8'h00, 48'h7A0000000000, 2);

        // busy_o falls within 3 clk of csn high.
        start_frame();
        send_bits(32'h9F, 8, m1);
        check("busy in frame", 48'(busy), 48'h1);
        csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("busy drop", 48'(busy), 48'h0);
        @(negedge clk);
        #300;

        // Asynchronous reset in the middle of DATA.
        start_frame();
        send_bits(32'h03, 8, m1);
        send_bits(32'h000040, 24, m1);
        send_bits($urandom, 3, m1);
        check("oe before reset", 48'(sdo_oe), 48'h1);
        check("addr before reset", 48'(mem_addr), 48'h000040);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", {42'h0, sdo, sdo_oe, mem_req, busy, 2'b00} | 48'(mem_addr), 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        oe0 = oe_cycles;
        q0 = req_log.size();
        send_bits($urandom, 16, m1);
        check("no frame w/o reselect", {46'h0, busy, 1'b0} | 48'(oe_cycles - oe0)
              | 48'(req_log.size() - q0), 48'h0);
        end_frame();
        verify("after reset", 8'h03, 24'h000055, 1, 8'h00, 48'h0F0000000000, 2);

        // Random frames against the model.
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: ropc = 8'h03;
                1: ropc = 8'h9F;
                2: ropc = 8'h05;
                default: begin
                    ropc = 8'($urandom);
                    while (ropc == 8'h03 || ropc == 8'h9F || ropc == 8'h05) ropc = 8'($urandom);
                end
            endcase
            raddr = 24'($urandom);
            rn = $urandom_range(1, 6);
            rst8 = 8'($urandom);
            verify($sformatf("rand%0d op%0h", i, ropc), ropc, raddr, rn, rst8,
                   model_bytes(ropc, raddr, rn, rst8), (ropc == 8'h03) ? rn + 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
